// File: rtl/vga_timing_scheduler.sv
// VGA raster timing: pixel/line counters, vertical phase FSM, sync/blank strobes,
// and a once-per-frame update window for game logic during vertical blanking.
module vga_timing_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 32
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       upd_req,
  input  logic       upd_done,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       video_active,
  output logic       line_start,
  output logic       frame_start,
  output logic       upd_grant,
  output logic       upd_abort
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_FP_START = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_BP_START = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {ST_ACT, ST_FP, ST_SYNC, ST_BP} vstate_e;

  vstate_e    state_q, state_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       active_q, active_d, line_q, line_d, frame_q, frame_d;
  logic       grant_q, grant_d, abort_q, abort_d, served_q, served_d;
  logic       window, revoke;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q  <= ST_ACT;
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b1;
      line_q   <= 1'b1;
      frame_q  <= 1'b1;
      grant_q  <= 1'b0;
      abort_q  <= 1'b0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      grant_q  <= grant_d;
      abort_q  <= abort_d;
      served_q <= served_d;
    end
  end

  // Flags are derived from the next counts so they line up with the registered counters.
  always_comb begin
    h_d = (h_q == H_MAX) ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_MAX) begin
      v_d = (v_q == V_MAX) ? 10'd0 : v_q + 10'd1;
    end

    state_d = state_q;
    if (h_d == 10'd0) begin
      case (state_q)
        ST_ACT:  if (v_d == V_FP_START) state_d = ST_FP;
        ST_FP:   if (v_d == VS_START)   state_d = ST_SYNC;
        ST_SYNC: if (v_d == V_BP_START) state_d = ST_BP;
        ST_BP:   if (v_d == 10'd0)      state_d = ST_ACT;
        default: state_d = ST_ACT;
      endcase
    end

    hsync_d  = !((h_d >= HS_START) && (h_d <= HS_END));
    vsync_d  = !((v_d >= VS_START) && (v_d <= VS_END));
    active_d = (h_d < H_ACT_END) && (v_d < V_FP_START);
    line_d   = (h_d == 10'd0);
    frame_d  = (h_d == 10'd0) && (v_d == 10'd0);
  end

  // Last line of blanking is a guard line: an outstanding grant is revoked on entry.
  always_comb begin
    window   = (state_q != ST_ACT) && (v_q < V_MAX);
    revoke   = grant_q && (h_d == 10'd0) && (v_d == V_MAX);
    grant_d  = grant_q;
    abort_d  = 1'b0;
    served_d = served_q;

    if (revoke) begin
      grant_d  = 1'b0;
      abort_d  = 1'b1;
      served_d = 1'b1;
    end else if (grant_q && upd_done) begin
      grant_d  = 1'b0;
      served_d = 1'b1;
    end else if (!grant_q && upd_req && window && !served_q && (v_d != V_MAX)) begin
      grant_d = 1'b1;
    end

    if (frame_d) begin
      served_d = 1'b0;
    end
  end

  assign h_count      = h_q;
  assign v_count      = v_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_active = active_q;
  assign line_start   = line_q;
  assign frame_start  = frame_q;
  assign upd_grant    = grant_q;
  assign upd_abort    = abort_q;

endmodule
